// File: rtl/hazard_tnew_pipe_if.sv
// hazard_tnew_pipe_if
// Groups the stall-unit facing signals of hazard_tnew_pipe into one bundle.
//   master : the pipeline/stall unit side. It drives the ID-stage info, the
//            combined stall and the EX mul/div start, and reads the slot state.
//   slave  : hazard_tnew_pipe itself.
// Signals
//   i_stall                         combined stall (freezes ID, bubbles EX)
//   i_id_reg_write / i_id_t_new     destination reg and T_new of the ID instruction
//   i_id_md_use                     ID instruction touches the mul/div unit or HI/LO
//   i_ex_md_start / i_ex_md_is_div  EX instruction starts a multiply or divide
//   o_{ex,mem,wb}_reg_write         destination register held in each slot
//   o_{ex,mem,wb}_t_new             remaining T_new held in each slot
//   o_md_busy / o_md_stall          mul/div occupied / extra stall request
interface hazard_tnew_pipe_if #(
  parameter int TNEW_W = 3
);
  logic              i_stall;
  logic [4:0]        i_id_reg_write;
  logic [TNEW_W-1:0] i_id_t_new;
  logic              i_id_md_use;
  logic              i_ex_md_start;
  logic              i_ex_md_is_div;

  logic [4:0]        o_ex_reg_write;
  logic [4:0]        o_mem_reg_write;
  logic [4:0]        o_wb_reg_write;
  logic [TNEW_W-1:0] o_ex_t_new;
  logic [TNEW_W-1:0] o_mem_t_new;
  logic [TNEW_W-1:0] o_wb_t_new;
  logic              o_md_busy;
  logic              o_md_stall;

  modport master (
    output i_stall, i_id_reg_write, i_id_t_new, i_id_md_use,
           i_ex_md_start, i_ex_md_is_div,
    input  o_ex_reg_write, o_mem_reg_write, o_wb_reg_write,
           o_ex_t_new, o_mem_t_new, o_wb_t_new, o_md_busy, o_md_stall
  );

  modport slave (
    input  i_stall, i_id_reg_write, i_id_t_new, i_id_md_use,
           i_ex_md_start, i_ex_md_is_div,
    output o_ex_reg_write, o_mem_reg_write, o_wb_reg_write,
           o_ex_t_new, o_mem_t_new, o_wb_t_new, o_md_busy, o_md_stall
  );
endinterface

// File: rtl/hazard_tnew_pipe.sv
// hazard_tnew_pipe
// Tracks the destination register and remaining result latency (T_new) of the
// instructions in the EX, MEM and WB slots so the stall unit can decide whether
// an operand can be forwarded in time. It also runs the mul/div busy counter and
// requests an extra stall when an HI/LO-touching instruction in ID would collide
// with a running or starting multiply/divide.
// Ports
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hazard_tnew_pipe_if.slave (see the interface file for its signals)
module hazard_tnew_pipe #(
  parameter int TNEW_W      = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_tnew_pipe_if.slave  bus
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [4:0]        r_ex_reg;
  logic [4:0]        r_mem_reg;
  logic [4:0]        r_wb_reg;
  logic [TNEW_W-1:0] r_ex_t_new;
  logic [TNEW_W-1:0] r_mem_t_new;
  logic [TNEW_W-1:0] r_wb_t_new;
  logic [CNT_W-1:0]  r_md_cnt;

  logic [4:0]        w_ex_reg_in;
  logic [TNEW_W-1:0] w_ex_t_new_in;
  logic              w_md_busy;

  // Saturating decrement: a result that is already forwardable stays at 0.
  function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  // A stall turns the EX capture into a bubble. An instruction without a
  // destination register never reports a pending result.
  always_comb begin
    w_ex_reg_in   = '0;
    w_ex_t_new_in = '0;
    if (!bus.i_stall) begin
      w_ex_reg_in   = bus.i_id_reg_write;
      w_ex_t_new_in = (bus.i_id_reg_write == 5'd0) ? '0 : bus.i_id_t_new;
    end
  end

  // EX/MEM/WB slots; MEM and WB advance every edge, independent of stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_reg    <= '0;
      r_ex_t_new  <= '0;
      r_mem_reg   <= '0;
      r_mem_t_new <= '0;
      r_wb_reg    <= '0;
      r_wb_t_new  <= '0;
    end else begin
      r_ex_reg    <= w_ex_reg_in;
      r_ex_t_new  <= w_ex_t_new_in;
      r_mem_reg   <= r_ex_reg;
      r_mem_t_new <= dec(r_ex_t_new);
      r_wb_reg    <= r_mem_reg;
      r_wb_t_new  <= dec(r_mem_t_new);
    end
  end

  // Mul/div busy counter. A start seen while the counter is running is
  // ignored; md_stall keeps such an instruction out of EX upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (r_md_cnt == '0) begin
      if (bus.i_ex_md_start) begin
        r_md_cnt <= bus.i_ex_md_is_div ? DIV_LOAD : MULT_LOAD;
      end
    end else begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  assign w_md_busy = (r_md_cnt != '0);

  assign bus.o_ex_reg_write  = r_ex_reg;
  assign bus.o_mem_reg_write = r_mem_reg;
  assign bus.o_wb_reg_write  = r_wb_reg;
  assign bus.o_ex_t_new      = r_ex_t_new;
  assign bus.o_mem_t_new     = r_mem_t_new;
  assign bus.o_wb_t_new      = r_wb_t_new;
  assign bus.o_md_busy       = w_md_busy;
  // The start term covers the cycle in which the operation is launched.
  assign bus.o_md_stall      = bus.i_id_md_use & (w_md_busy | bus.i_ex_md_start);

endmodule

// File: tb/tb_hazard_tnew_pipe.sv
// tb_hazard_tnew_pipe
// Self-checking bench for hazard_tnew_pipe. The reference model keeps a history
// of what entered EX at every clock edge and derives each slot's expected
// T_new as (entry T_new - age), floored at zero. The mul/div unit is modelled
// as "busy through edge start+N-1".
module tb_hazard_tnew_pipe;
  localparam int TNEW_W      = 3;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int HIST        = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: edgeCnt counts clock edges taken out of reset; histReg/histTnew
  // hold what entered EX at each edge; mdEndEdge is the last busy edge.
  int edgeCnt;
  int mdEndEdge;
  int histReg[HIST];
  int histTnew[HIST];

  hazard_tnew_pipe_if #(.TNEW_W(TNEW_W)) bus ();

  hazard_tnew_pipe #(
    .TNEW_W(TNEW_W),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int satSub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  function automatic bit modelBusy();
    return edgeCnt <= mdEndEdge;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compares every output against the model for the current edge count.
  task automatic checkOutput(input string step);
    logic [31:0] expStall;
    expStall = {31'd0, bus.i_id_md_use & (modelBusy() | bus.i_ex_md_start)};
    chk({step, ":ex_reg"},   {27'd0, bus.o_ex_reg_write},  histReg[edgeCnt]);
    chk({step, ":ex_tnew"},  {29'd0, bus.o_ex_t_new},      histTnew[edgeCnt]);
    chk({step, ":mem_reg"},  {27'd0, bus.o_mem_reg_write}, histReg[edgeCnt-1]);
    chk({step, ":mem_tnew"}, {29'd0, bus.o_mem_t_new},     satSub(histTnew[edgeCnt-1], 1));
    chk({step, ":wb_reg"},   {27'd0, bus.o_wb_reg_write},  histReg[edgeCnt-2]);
    chk({step, ":wb_tnew"},  {29'd0, bus.o_wb_t_new},      satSub(histTnew[edgeCnt-2], 2));
    chk({step, ":md_busy"},  {31'd0, bus.o_md_busy},       {31'd0, modelBusy()});
    chk({step, ":md_stall"}, {31'd0, bus.o_md_stall},      expStall);
  endtask

  // Called at a falling edge: drives one cycle of inputs, checks md_stall
  // before the rising edge, advances the model and checks all outputs after.
  task automatic applyStimulus(input bit stall, input int regW, input int tNew,
                               input bit mdUse, input bit start, input bit isDiv,
                               input string step);
    bus.i_stall        = stall;
    bus.i_id_reg_write = regW[4:0];
    bus.i_id_t_new     = tNew[TNEW_W-1:0];
    bus.i_id_md_use    = mdUse;
    bus.i_ex_md_start  = start;
    bus.i_ex_md_is_div = isDiv;
    #1;
    chk({step, ":pre_md_stall"}, {31'd0, bus.o_md_stall},
        {31'd0, mdUse & (modelBusy() | start)});
    if (start) chk({step, ":start_legal"}, {31'd0, bus.o_md_busy}, 32'd0);
    @(posedge clk);
    if (start && !modelBusy())
      mdEndEdge = edgeCnt + (isDiv ? DIV_CYCLES : MULT_CYCLES);
    edgeCnt++;
    histReg[edgeCnt]  = stall ? 0 : regW;
    histTnew[edgeCnt] = (stall || regW == 0) ? 0 : tNew;
    #1;
    checkOutput(step);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, released at a falling edge.
  task automatic doReset(input string step);
    #2;
    rst_n = 1'b0;
    #1;
    histReg[edgeCnt]    = 0;
    histTnew[edgeCnt]   = 0;
    histReg[edgeCnt-1]  = 0;
    histTnew[edgeCnt-1] = 0;
    histReg[edgeCnt-2]  = 0;
    histTnew[edgeCnt-2] = 0;
    mdEndEdge = -1;
    checkOutput({step, ":async"});
    @(posedge clk);
    #1;
    checkOutput({step, ":held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    edgeCnt   = 2;
    mdEndEdge = -1;
    for (int i = 0; i < 3; i++) begin
      histReg[i]  = 0;
      histTnew[i] = 0;
    end

    bus.i_stall        = 1'b0;
    bus.i_id_reg_write = 5'd0;
    bus.i_id_t_new     = '0;
    bus.i_id_md_use    = 1'b1;
    bus.i_ex_md_start  = 1'b1;
    bus.i_ex_md_is_div = 1'b0;
    rst_n              = 1'b0;

    @(negedge clk);
    checkOutput("reset_start");
    bus.i_ex_md_start = 1'b0;
    #1;
    checkOutput("reset_idle");
    @(negedge clk);
    rst_n = 1'b1;

    // lw $3 (T_new 2) walks through EX/MEM/WB; then a write to $0 with T_new 3
    applyStimulus(0, 3, 2, 0, 0, 0, "lw_e1");
    applyStimulus(0, 0, 3, 0, 0, 0, "zero_e2");
    applyStimulus(0, 0, 0, 0, 0, 0, "lw_e3");
    applyStimulus(0, 0, 0, 0, 0, 0, "zero_e4");

    // two stall cycles with {5,1} waiting in ID
    applyStimulus(0, 7, 3, 0, 0, 0, "pre_stall");
    applyStimulus(1, 5, 1, 0, 0, 0, "stall1");
    applyStimulus(1, 5, 1, 0, 0, 0, "stall2");
    applyStimulus(0, 5, 1, 0, 0, 0, "unstall");

    // T_new 1 must saturate at 0 downstream
    applyStimulus(0, 9, 1, 0, 0, 0, "tnew1_e1");
    applyStimulus(0, 0, 0, 0, 0, 0, "tnew1_e2");
    applyStimulus(0, 0, 0, 0, 0, 0, "tnew1_e3");

    // multiply start with an HI/LO user in ID, then the busy window
    applyStimulus(0, 0, 0, 1, 1, 0, "mult_start");
    for (int i = 1; i <= MULT_CYCLES; i++)
      applyStimulus(0, 0, 0, 1, 0, 0, $sformatf("mult_c%0d", i));

    // divide start, reset during busy cycle 4, stays idle afterwards
    applyStimulus(0, 4, 2, 1, 1, 1, "div_start");
    for (int i = 2; i <= 4; i++)
      applyStimulus(0, 6, 1, 1, 0, 0, $sformatf("div_c%0d", i));
    doReset("div_reset");
    for (int i = 0; i < DIV_CYCLES + 2; i++)
      applyStimulus(0, 0, 0, 1, 0, 0, $sformatf("post_reset_%0d", i));

    // randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      bit rStall, rUse, rStart, rDiv;
      int rReg, rTnew;
      rStall = ($urandom_range(3) == 0);
      rReg   = $urandom_range(31);
      rTnew  = $urandom_range(7);
      rUse   = $urandom_range(1) == 1;
      rStart = !modelBusy() && ($urandom_range(2) == 0);
      rDiv   = $urandom_range(1) == 1;
      if ($urandom_range(59) == 0)
        doReset($sformatf("rand_reset_%0d", i));
      else
        applyStimulus(rStall, rReg, rTnew, rUse, rStart, rDiv, $sformatf("rand_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
